// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if
//   Bundles the request port, response port, processor-bus field lines and
//   the IBus data/drive lines of the ALU card sequencer.
//
//   Handshake rule for both req_* and rsp_*: a transfer happens on a rising
//   clk4 edge where valid and ready are both high. The producer holds valid
//   and its payload until that edge. The consumer may raise or drop ready at
//   any time.
//
//   Modports:
//     slave  - the sequencer: takes requests, drives the bus fields, offers responses
//     master - the microcode sequencer or harness that issues requests
//
//   Signals:
//     req_valid/req_ready, req_kind[1:0], req_op[2:0], req_b[15:0], req_ir[6:0]
//     raddr[4:0], waddr[4:0], action[3:0], ir_6_0[6:0]
//     ibus_out[15:0], ibus_oe, ibus_in[15:0]
//     rsp_valid/rsp_ready, rsp_data[15:0]
//     busy, state_dbg[2:0] (current FSM state encoding, for observation only)
interface alu_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic [2:0]  req_op;
    logic [15:0] req_b;
    logic [6:0]  req_ir;

    logic [4:0]  raddr;
    logic [4:0]  waddr;
    logic [3:0]  action;
    logic [6:0]  ir_6_0;

    logic [15:0] ibus_out;
    logic        ibus_oe;
    logic [15:0] ibus_in;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;

    logic        busy;
    logic [2:0]  state_dbg;

    modport slave (
        input  req_valid, req_kind, req_op, req_b, req_ir, ibus_in, rsp_ready,
        output req_ready, raddr, waddr, action, ir_6_0, ibus_out, ibus_oe,
               rsp_valid, rsp_data, busy, state_dbg
    );

    modport master (
        output req_valid, req_kind, req_op, req_b, req_ir, ibus_in, rsp_ready,
        input  req_ready, raddr, waddr, action, ir_6_0, ibus_out, ibus_oe,
               rsp_valid, rsp_data, busy, state_dbg
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Microcode-side driver for the ALU card. Accepts one request at a time
//   (ALU ROM op, SRU shift/rotate, CLL, CPL), plays out the per-cycle
//   raddr/waddr/action field sequence the ALU card decodes, captures the
//   result from IBus and returns it on the response port.
//
//   Ports:
//     clk4  - processor clock, all flops on the rising edge
//     reset - synchronous, active-high
//     bus   - alu_sequencer_if.slave (request, bus fields, IBus, response)
//
//   Sequences (one state per cycle unless noted):
//     ALU op : WRB -> RD -> RESP
//     SRU    : WRB -> ACT -> WAIT x (distance+1) -> RD -> RESP
//     CLL/CPL: ACT -> RESP
//
//   Every output is registered. The register inputs are computed from the
//   next state, so each field lines up exactly with the state it belongs to.
module alu_sequencer (
    input  logic              clk4,
    input  logic              reset,
    alu_sequencer_if.slave    bus
);

    localparam logic [4:0] RADDR_ALU_BASE = 5'b11000;
    localparam logic [4:0] RADDR_ALU_B    = 5'b10111;
    localparam logic [4:0] WADDR_ALU_B    = 5'b10111;
    localparam logic [3:0] ACTION_SRU     = 4'b0100;
    localparam logic [3:0] ACTION_CLL     = 4'b0010;
    localparam logic [3:0] ACTION_CPL     = 4'b0011;

    localparam logic [1:0] KIND_ALU = 2'b00;
    localparam logic [1:0] KIND_SRU = 2'b01;
    localparam logic [1:0] KIND_CLL = 2'b10;
    localparam logic [1:0] KIND_CPL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WRB  = 3'd1,
        S_ACT  = 3'd2,
        S_WAIT = 3'd3,
        S_RD   = 3'd4,
        S_RESP = 3'd5
    } state_t;

    state_t      state_q, state_d;

    // Request fields latched on the accept edge.
    logic [1:0]  kind_q;
    logic [2:0]  op_q;
    logic [15:0] b_q;
    logic [6:0]  ir_q;

    // SRU wait counter; 5 bits so that distance 15 + 1 = 16 fits.
    logic [4:0]  cnt_q;

    logic        accept;

    // Request fields as they will be seen after this edge. On the accept
    // edge the latches are not yet loaded, so the live request is used.
    logic [1:0]  kind_n;
    logic [2:0]  op_n;
    logic [15:0] b_n;
    logic [6:0]  ir_n;

    // Next values of the registered outputs.
    logic [4:0]  raddr_d;
    logic [4:0]  waddr_d;
    logic [3:0]  action_d;
    logic        oe_d;
    logic [15:0] out_d;
    logic [6:0]  ir_out_d;

    assign accept = (state_q == S_IDLE) && bus.req_valid;

    assign kind_n = accept ? bus.req_kind : kind_q;
    assign op_n   = accept ? bus.req_op   : op_q;
    assign b_n    = accept ? bus.req_b    : b_q;
    assign ir_n   = accept ? bus.req_ir   : ir_q;

    assign bus.state_dbg = state_q;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    // Kinds 1x (CLL/CPL) carry no operand, so skip the port B write.
                    state_d = bus.req_kind[1] ? S_ACT : S_WRB;
                end
            end
            S_WRB: begin
                state_d = (kind_q == KIND_ALU) ? S_RD : S_ACT;
            end
            S_ACT: begin
                state_d = (kind_q == KIND_SRU) ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                // <= 1 rather than == 1 so a zero count can never stall here.
                if (cnt_q <= 5'd1) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Field values for the cycle that follows this edge.
    always_comb begin
        raddr_d  = 5'd0;
        waddr_d  = 5'd0;
        action_d = 4'd0;
        oe_d     = 1'b0;
        out_d    = 16'h0000;
        ir_out_d = (state_d == S_IDLE) ? 7'd0 : ir_n;
        case (state_d)
            S_WRB: begin
                waddr_d = WADDR_ALU_B;
                oe_d    = 1'b1;
                out_d   = b_n;
            end
            S_ACT: begin
                case (kind_n)
                    KIND_SRU: action_d = ACTION_SRU;
                    KIND_CLL: action_d = ACTION_CLL;
                    KIND_CPL: action_d = ACTION_CPL;
                    default:  action_d = 4'd0;
                endcase
            end
            S_RD: begin
                raddr_d = (kind_n == KIND_ALU) ? (RADDR_ALU_BASE | {2'b00, op_n})
                                               : RADDR_ALU_B;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk4) begin
        if (reset) begin
            state_q       <= S_IDLE;
            kind_q        <= 2'd0;
            op_q          <= 3'd0;
            b_q           <= 16'h0000;
            ir_q          <= 7'd0;
            cnt_q         <= 5'd0;
            bus.req_ready <= 1'b1;
            bus.busy      <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= 16'h0000;
            bus.raddr     <= 5'd0;
            bus.waddr     <= 5'd0;
            bus.action    <= 4'd0;
            bus.ir_6_0    <= 7'd0;
            bus.ibus_oe   <= 1'b0;
            bus.ibus_out  <= 16'h0000;
        end else begin
            state_q <= state_d;

            if (accept) begin
                kind_q <= bus.req_kind;
                op_q   <= bus.req_op;
                b_q    <= bus.req_b;
                ir_q   <= bus.req_ir;
            end

            if (state_q == S_ACT && kind_q == KIND_SRU) begin
                cnt_q <= {1'b0, ir_q[3:0]} + 5'd1;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - 5'd1;
            end

            // Result is sampled on the edge that closes the RD cycle;
            // CLL/CPL return zero.
            if (state_q == S_RD) begin
                bus.rsp_data <= bus.ibus_in;
            end else if (state_q == S_ACT && state_d == S_RESP) begin
                bus.rsp_data <= 16'h0000;
            end

            bus.req_ready <= (state_d == S_IDLE);
            bus.busy      <= (state_d != S_IDLE);
            bus.rsp_valid <= (state_d == S_RESP);
            bus.raddr     <= raddr_d;
            bus.waddr     <= waddr_d;
            bus.action    <= action_d;
            bus.ibus_oe   <= oe_d;
            bus.ibus_out  <= out_d;
            bus.ir_6_0    <= ir_out_d;
        end
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Microcode-side driver for the ALU card. It accepts one ALU request at a time over a valid/ready handshake and plays out the per-cycle `raddr`/`waddr`/`action` field sequence on the processor bus that the ALU card decodes. Supported requests are an ALU ROM op, an SRU shift/rotate, CLL and CPL. For requests that produce data, it captures the result from `ibus` and returns it on a valid/ready response port. It sits between the microcode sequencer or test harness and the backplane IBus / microcode-field lines.

## Interface
- `RADDR_ALU_BASE`, 5'b11000: ALU ROM read base; ROM op is OR-ed into bits [2:0].
- `RADDR_ALU_B`, 5'b10111: read address returning ALU port B (SRU result).
- `WADDR_ALU_B`, 5'b10111: write address loading ALU port B.
- `ACTION_SRU`, 4'b0100: action code that starts the SRU.
- `ACTION_CLL`, 4'b0010: action code that clears L.
- `ACTION_CPL`, 4'b0011: action code that complements L.
- `clk4`  in  1  processor clock; every flop updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  block can accept; high only in IDLE.
- `req_kind`  in  2  00=ALU op, 01=SRU, 10=CLL, 11=CPL.
- `req_op`  in  3  ALU ROM op (kind 00 only).
- `req_b`  in  16  operand written to port B (kinds 00/01).
- `req_ir`  in  7  SRU operand: [3:0] distance, [4] right, [5] arithmetic, [6] rotate.
- `raddr`  out  5  IBus read address; idle 5'd0.
- `waddr`  out  5  IBus write address; idle 5'd0.
- `action`  out  4  action field; idle 4'd0.
- `ir_6_0`  out  7  IR[6:0] presented to the ALU card's C port.
- `ibus_out`  out  16  data driven onto IBus.
- `ibus_oe`  out  1  IBus drive enable.
- `ibus_in`  in  16  IBus sample.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  response consumed.
- `rsp_data`  out  16  captured result.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, WRB, ACT, WAIT, RD, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch `req_kind`, `req_op`, `req_b` and `req_ir`.
  - kind 00/01 go to WRB.
  - kind 10/11 go to ACT.
- WRB, one cycle: `waddr`=`WADDR_ALU_B`, `ibus_oe`=1, `ibus_out`=latched b.
  - kind 00 goes to RD; kind 01 goes to ACT.
- ACT, one cycle: `action` is `ACTION_SRU`, `ACTION_CLL` or `ACTION_CPL` according to kind.
  - SRU loads the wait counter with distance+1 and goes to WAIT.
  - CLL/CPL go to RESP with `rsp_data`=16'h0000.
- WAIT: the counter decrements once per cycle, and all fields stay idle. Go to RD in the cycle the counter reads 1.
- RD, one cycle: `raddr` is `RADDR_ALU_BASE`|op for kind 00, or `RADDR_ALU_B` for kind 01.
  - `ibus_in` is captured into `rsp_data` on the closing edge.
  - Go to RESP.
- RESP: `rsp_valid`=1 and `rsp_data` is stable. On `rsp_ready`, return to IDLE.
- `ir_6_0` holds the latched `req_ir` from the accept edge until RESP exits; it is 7'd0 in IDLE.
- `ibus_oe` is never high in the same cycle as a non-zero `raddr`.
- `ibus_out` is 16'h0000 whenever `ibus_oe`=0.
- A request cannot be accepted during RESP; there is no back-to-back overlap.

## Timing
- Reset values: state IDLE, `req_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_data`=0, `raddr`/`waddr`/`action`=0, `ir_6_0`=0, `ibus_oe`=0, `ibus_out`=0, counter 0.
- Latency is counted from accept edge E to the first cycle with `rsp_valid`=1:
  - ALU op: E+3 (WRB, RD, then RESP).
  - SRU: E+4+(distance+1). Distance 0 gives 1 WAIT cycle; distance 15 gives 16.
  - CLL/CPL: E+2.
- All outputs are registered, so each field is stable for its whole cycle.
- `rsp_valid` and `rsp_ready` high in the same cycle: the handshake completes and `req_ready` rises the next cycle.
- Reset asserted in any state, including mid-WAIT or during RESP: the next edge forces the reset values. The in-flight request is discarded and no response is issued.
- `req_valid` dropping while busy has no effect.
- Changes on `req_*` after accept are ignored.

## Test plan
- Reset, then ALU op=3 with b=16'h1234, `ibus_in` forced to 16'hABCD during RD:
  - WRB cycle shows `waddr`=10111 and `ibus_out`=1234 with `oe`=1.
  - RD cycle shows `raddr`=11011.
  - `rsp_data`=ABCD with `rsp_valid` at E+3.
- SRU with `req_ir`=7'b1010101 (rotate, right, distance 5):
  - `action`=0100 in ACT, followed by exactly 6 WAIT cycles.
  - RD cycle shows `raddr`=10111.
  - `ir_6_0`=1010101 throughout, then 0 in IDLE.
- CLL, then CPL: `action`=0010 and 0011 for one cycle each, `rsp_data`=0, `rsp_valid` at E+2.
- `rsp_ready` held low for 10 cycles: `rsp_valid` and `rsp_data` stay stable, `req_ready` stays 0, and a new `req_valid` is ignored.
- Reset pulsed during WAIT of a distance-15 SRU: all outputs return to reset values on the next edge and no response appears. A following ALU op then completes normally.
